// File: rtl/control_flow_unit_l4_if.sv
// Handshake bundles for the control-flow unit: decode->execute (D) and execute->writeback (W).

interface d_x_intf #(
  parameter int unsigned p_seq_num_bits = 5
);
  logic                      val;
  logic                      rdy;
  logic [31:0]               pc;
  logic [p_seq_num_bits-1:0] seq_num;
  logic [31:0]               op1;
  logic [31:0]               op2;
  logic [31:0]               op3_branch_imm;
  logic [4:0]                waddr;
  logic [3:0]                uop;
  logic [5:0]                preg;
  logic [5:0]                ppreg;

  modport master (
    output val, pc, seq_num, op1, op2, op3_branch_imm, waddr, uop, preg, ppreg,
    input  rdy
  );
  modport slave (
    input  val, pc, seq_num, op1, op2, op3_branch_imm, waddr, uop, preg, ppreg,
    output rdy
  );
endinterface

interface x_w_intf #(
  parameter int unsigned p_seq_num_bits = 5
);
  logic                      val;
  logic                      rdy;
  logic [31:0]               pc;
  logic [p_seq_num_bits-1:0] seq_num;
  logic [4:0]                waddr;
  logic [31:0]               wdata;
  logic                      wen;

  modport master (
    output val, pc, seq_num, waddr, wdata, wen,
    input  rdy
  );
  modport slave (
    input  val, pc, seq_num, waddr, wdata, wen,
    output rdy
  );
endinterface

// File: rtl/control_flow_unit_l4.sv
// Single-stage JAL/JALR execute unit: writes the link address (pc + 4) and
// computes the jump target internally for the trace view.

module control_flow_unit_l4 #(
  parameter int unsigned p_seq_num_bits = 5
) (
  input logic  clk,
  input logic  rst,
  d_x_intf.slave d,
  x_w_intf.master w
);

  localparam logic [3:0] UopJal  = 4'd1;
  localparam logic [3:0] UopJalr = 4'd2;

  logic                      val_q;
  logic [31:0]               pc_q;
  logic [p_seq_num_bits-1:0] seq_q;
  logic [4:0]                waddr_q;
  logic [31:0]               wdata_q;
  logic                      wen_q;
  logic [3:0]                uop_q;
  logic [31:0]               target_q;

  logic                      d_fire;
  logic [31:0]               target_d;
  logic                      is_jump;
  logic [175:0]              trace_str;
  logic                      unused_sink;

  // Accept whenever the output slot is empty or is draining this cycle.
  assign d.rdy  = !val_q || w.rdy;
  assign d_fire = d.val && d.rdy;

  // Decode jump kind and compute the (non-architectural) target.
  always_comb begin
    target_d = '0;
    is_jump  = 1'b0;
    case (d.uop)
      UopJal: begin
        target_d = d.pc + d.op3_branch_imm;
        is_jump  = 1'b1;
      end
      UopJalr: begin
        target_d = (d.op1 + d.op3_branch_imm) & ~32'h1;
        is_jump  = 1'b1;
      end
      default: ;
    endcase
  end

  // Valid bit: async clear drops any held instruction; otherwise refill on drain/empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val_q <= 1'b0;
    end else if (d.rdy) begin
      val_q <= d.val;
    end
  end

  // Datapath payload; contents are don't-care while val_q is low.
  always_ff @(posedge clk) begin
    if (d_fire) begin
      pc_q     <= d.pc;
      seq_q    <= d.seq_num;
      waddr_q  <= d.waddr;
      wdata_q  <= d.pc + 32'd4;
      wen_q    <= is_jump;
      uop_q    <= d.uop;
      target_q <= target_d;
    end
  end

  assign w.val     = val_q;
  assign w.pc      = pc_q;
  assign w.seq_num = seq_q;
  assign w.waddr   = waddr_q;
  assign w.wdata   = wdata_q;
  assign w.wen     = wen_q;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
  endfunction

  // 22 chars: "NAME wwwwwwww tttttttt" (uop, wdata, target); all blanks when idle.
  function automatic logic [175:0] trace();
    logic [175:0] s;
    s = {22{8'h20}};
    if (val_q) begin
      case (uop_q)
        UopJal:  s[175:144] = "JAL ";
        UopJalr: s[175:144] = "JALR";
        default: s[175:144] = "OTH ";
      endcase
      for (int i = 0; i < 8; i++) begin
        s[135-8*i -: 8] = hex_char(wdata_q[31-4*i -: 4]);
        s[63-8*i -: 8]  = hex_char(target_q[31-4*i -: 4]);
      end
    end
    return s;
  endfunction

  // Trace view for simulation/debug probing.
  always_comb begin
    trace_str = trace();
  end

  // op2/preg/ppreg are carried by the bundle but never consumed here.
  assign unused_sink = ^{d.op2, d.preg, d.ppreg, trace_str};

endmodule

// File: tb/tb_control_flow_unit_l4.sv
module tb_control_flow_unit_l4;

  localparam int unsigned SeqBits = 3;
  localparam logic [3:0] UJal  = 4'd1;
  localparam logic [3:0] UJalr = 4'd2;

  logic clk;
  logic rst;

  d_x_intf #(.p_seq_num_bits(SeqBits)) d_bus ();
  x_w_intf #(.p_seq_num_bits(SeqBits)) w_bus ();

  control_flow_unit_l4 #(.p_seq_num_bits(SeqBits)) dut (
    .clk (clk),
    .rst (rst),
    .d   (d_bus),
    .w   (w_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]        pc;
    logic [SeqBits-1:0] seq;
    logic [4:0]         waddr;
    logic [31:0]        wdata;
    logic               wen;
    logic               jump;
    logic [31:0]        target;
  } exp_t;

  exp_t pending[$];
  int total = 0;
  int bad = 0;
  logic [SeqBits-1:0] seq_ctr = '0;

  task automatic check_eq(input string tag, input logic [175:0] got, input logic [175:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference behaviour of one instruction, straight from the ISA rules.
  function automatic exp_t model(input logic [3:0] uop, input logic [31:0] pc, op1, imm,
                                 input logic [4:0] waddr, input logic [SeqBits-1:0] seq);
    exp_t e;
    e.pc     = pc;
    e.seq    = seq;
    e.waddr  = waddr;
    e.wdata  = pc + 32'd4;
    e.jump   = (uop == UJal) || (uop == UJalr);
    e.wen    = e.jump;
    e.target = (uop == UJal) ? pc + imm : ((op1 + imm) & 32'hFFFF_FFFE);
    return e;
  endfunction

  // One clock: drive at posedge+1, check at negedge, advance the model, return at posedge+1.
  task automatic step(input logic dv, input logic [3:0] uop, input logic [31:0] pc, op1, imm,
                      input logic [4:0] waddr, input logic wr);
    logic busy;
    logic wfire;
    logic dfire;
    d_bus.val            = dv;
    d_bus.uop            = uop;
    d_bus.pc             = pc;
    d_bus.op1            = op1;
    d_bus.op2            = $urandom;
    d_bus.op3_branch_imm = imm;
    d_bus.waddr          = waddr;
    d_bus.seq_num        = seq_ctr;
    d_bus.preg           = 6'($urandom);
    d_bus.ppreg          = 6'($urandom);
    w_bus.rdy            = wr;
    @(negedge clk);
    busy = (pending.size() != 0);
    check_eq("w_val", 176'(w_bus.val), 176'(busy));
    check_eq("d_rdy", 176'(d_bus.rdy), 176'(!busy || wr));
    if (busy) begin
      check_eq("w_pc", 176'(w_bus.pc), 176'(pending[0].pc));
      check_eq("w_seq", 176'(w_bus.seq_num), 176'(pending[0].seq));
      check_eq("w_waddr", 176'(w_bus.waddr), 176'(pending[0].waddr));
      check_eq("w_wdata", 176'(w_bus.wdata), 176'(pending[0].wdata));
      check_eq("w_wen", 176'(w_bus.wen), 176'(pending[0].wen));
      if (pending[0].jump) check_eq("target", 176'(dut.target_q), 176'(pending[0].target));
    end
    wfire = busy && wr;
    dfire = dv && (!busy || wr);
    if (wfire) void'(pending.pop_front());
    if (dfire) begin
      pending.push_back(model(uop, pc, op1, imm, waddr, seq_ctr));
      seq_ctr = seq_ctr + 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic wr);
    step(1'b0, 4'd0, 32'd0, 32'd0, 32'd0, 5'd0, wr);
  endtask

  initial begin
    d_bus.val = 1'b0;
    d_bus.uop = '0;
    d_bus.pc = '0;
    d_bus.op1 = '0;
    d_bus.op2 = '0;
    d_bus.op3_branch_imm = '0;
    d_bus.waddr = '0;
    d_bus.seq_num = '0;
    d_bus.preg = '0;
    d_bus.ppreg = '0;
    w_bus.rdy = 1'b1;
    rst = 1'b1;
    #1;
    check_eq("rst_w_val", 176'(w_bus.val), 176'(1'b0));
    check_eq("rst_d_rdy", 176'(d_bus.rdy), 176'(1'b1));
    check_eq("rst_trace", dut.trace_str, {22{8'h20}});
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed JAL: result one cycle later, trace shows name/link/target.
    seq_ctr = 3'd1;
    step(1'b1, UJal, 32'h0000_0200, 32'h0, 32'h10, 5'd1, 1'b1);
    check_eq("jal_trace", dut.trace_str, "JAL  00000204 00000210");
    idle(1'b1);
    // Directed JALR with odd target cleared to even.
    step(1'b1, UJalr, 32'h0000_1000, 32'h2003, 32'h4, 5'd5, 1'b1);
    check_eq("jalr_target", 176'(dut.target_q), 176'(32'h2006));
    idle(1'b1);
    // pc wrap and x0 destination still write-enabled.
    step(1'b1, UJal, 32'hFFFF_FFFC, 32'h0, 32'h8, 5'd0, 1'b1);
    check_eq("wrap_wdata", 176'(w_bus.wdata), 176'(32'h0));
    idle(1'b1);
    // Non-jump uop passes through with wen low.
    step(1'b1, 4'd7, 32'h0000_0040, 32'h0, 32'h0, 5'd9, 1'b1);
    idle(1'b1);

    // Eight back-to-back jumps; seq tag wraps 7 -> 0.
    seq_ctr = 3'd4;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, (i % 2 == 0) ? UJal : UJalr, 32'h100 + 32'(i) * 4, 32'h300 + 32'(i),
           32'(i) * 8, 5'(i + 3), 1'b1);
    end
    idle(1'b1);

    // Backpressure: held result, D blocked, nothing lost.
    step(1'b1, UJal, 32'h0000_0800, 32'h0, 32'h20, 5'd7, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, UJalr, 32'h0000_0900, 32'h55, 32'h3, 5'd8, 1'b0);
    end
    step(1'b1, UJalr, 32'h0000_0900, 32'h55, 32'h3, 5'd8, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // Reset while a stalled result is held: it must vanish at once.
    step(1'b1, UJal, 32'h0000_0A00, 32'h0, 32'h4, 5'd2, 1'b0);
    idle(1'b0);
    rst = 1'b1;
    #1;
    check_eq("midrst_w_val", 176'(w_bus.val), 176'(1'b0));
    check_eq("midrst_d_rdy", 176'(d_bus.rdy), 176'(1'b1));
    pending.delete();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    step(1'b1, UJalr, 32'h0000_0B00, 32'h1001, 32'h0, 5'd4, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, 4'($urandom_range(0, 4)), $urandom & 32'hFFFF_FFFC,
           $urandom, $urandom, 5'($urandom), $urandom_range(0, 3) != 0);
    end
    for (int i = 0; i < 3; i++) idle(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
